// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: FSM state encoding and source indices.
package irq_pkg;
    typedef enum logic [1:0] {IRQ_IDLE, IRQ_PRESENT, IRQ_SERVICE} irq_state_t;

    localparam int IRQ_ETH = 0;
    localparam int IRQ_KEY = 1;
endpackage

// File: rtl/irq_ctrl_if.sv
// Core-facing interrupt handshake: controller presents valid/id/data, core answers ack/done.
interface irq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) ();
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic [DATA_W-1:0] irq_data;
    logic              irq_ack;
    logic              irq_done;

    modport master (output irq_valid, irq_id, irq_data, input irq_ack, irq_done);
    modport slave  (input irq_valid, irq_id, irq_data, output irq_ack, irq_done);
endinterface

// File: rtl/irq_edge_latch.sv
// Per-source rising-edge capture: pending flag, first-wins payload and sticky overflow.
module irq_edge_latch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    input  logic              ovf_clr,
    output logic              pending,
    output logic [DATA_W-1:0] data_q,
    output logic              ovf
);
    logic prev;
    logic armed;
    logic evt;

    // armed gates the first post-reset cycle so a level held through reset is not an edge
    assign evt = irq & ~prev & armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= 1'b0;
            armed   <= 1'b0;
            pending <= 1'b0;
            data_q  <= '0;
            ovf     <= 1'b0;
        end else begin
            prev  <= irq;
            armed <= 1'b1;
            if (ovf_clr) ovf <= 1'b0;
            if (clr) pending <= 1'b0;
            // clear-then-set: an edge coincident with the ack re-pends with fresh data
            if (evt) begin
                if (pending && !clr) begin
                    ovf <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    data_q  <= data;
                end
            end
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: one irq at a time via valid/ack/done, no nesting.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      mask_we,
    input  logic [NUM_SRC-1:0]        mask_wdata,
    irq_ctrl_if.master                bus,
    output logic [NUM_SRC-1:0]        irq_ovf
);
    irq_state_t                       state;
    logic [NUM_SRC-1:0]               mask;
    logic [NUM_SRC-1:0]               pending;
    logic [NUM_SRC-1:0]               clr;
    logic [NUM_SRC-1:0]               ovf_clr;
    logic [NUM_SRC-1:0][DATA_W-1:0]   data_q;
    logic [NUM_SRC-1:0]               req;
    logic [ID_W-1:0]                  pick;
    logic [ID_W-1:0]                  sel;
    logic                             valid_q;
    logic [DATA_W-1:0]                data_out;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign clr[i]     = (state == IRQ_PRESENT) && bus.irq_ack && (sel == ID_W'(i));
        assign ovf_clr[i] = mask_we && !mask_wdata[i];

        irq_edge_latch #(.DATA_W(DATA_W)) u_latch (
            .clk     (clk),
            .rst     (rst),
            .irq     (src_irq[i]),
            .data    (src_data[i*DATA_W +: DATA_W]),
            .clr     (clr[i]),
            .ovf_clr (ovf_clr[i]),
            .pending (pending[i]),
            .data_q  (data_q[i]),
            .ovf     (irq_ovf[i])
        );
    end

    assign req = pending & mask;

    // lowest index wins: scan from the top so the last hit is the highest priority
    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) pick = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IRQ_IDLE;
            mask     <= '1;
            sel      <= '0;
            valid_q  <= 1'b0;
            data_out <= '0;
        end else begin
            if (mask_we) mask <= mask_wdata;
            case (state)
                IRQ_IDLE: begin
                    if (|req) begin
                        state    <= IRQ_PRESENT;
                        sel      <= pick;
                        valid_q  <= 1'b1;
                        data_out <= data_q[pick];
                    end
                end
                IRQ_PRESENT: begin
                    if (bus.irq_ack) begin
                        state   <= IRQ_SERVICE;
                        valid_q <= 1'b0;
                    end else if (!mask[sel]) begin
                        state   <= IRQ_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (bus.irq_done) state <= IRQ_IDLE;
                end
                default: begin
                    state   <= IRQ_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = sel;
    assign bus.irq_data  = data_out;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; presentations are checked by a scoreboard monitor.
module tb_irq_ctrl;
    import irq_pkg::*;

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_irq;
    logic [63:0] src_data;
    logic        mask_we;
    logic [1:0]  mask_wdata;
    logic [1:0]  irq_ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic pv = 1'b0;

    irq_ctrl_if #(.DATA_W(32), .ID_W(1)) bus ();

    irq_ctrl #(.NUM_SRC(2), .DATA_W(32), .ID_W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .src_data   (src_data),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .bus        (bus),
        .irq_ovf    (irq_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every new presentation must match the oldest expected entry
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            pv <= bus.irq_valid;
            if (bus.irq_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_irq: got id %0d data %0h expected none",
                             bus.irq_id, bus.irq_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(bus.irq_id), 64'(e.id));
                    chk("sb_data", 64'(bus.irq_data), 64'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [0:0] id, input logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int idx, input logic [31:0] d);
        src_irq[idx]           = 1'b1;
        src_data[idx*32 +: 32] = d;
        step();
        src_irq[idx] = 1'b0;
    endtask

    task automatic mask_write(input logic [1:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
    endtask

    task automatic do_done();
        bus.irq_done = 1'b1;
        step();
        bus.irq_done = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        src_irq      = '0;
        src_data     = '0;
        mask_we      = 1'b0;
        mask_wdata   = '0;
        bus.irq_ack  = 1'b0;
        bus.irq_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.irq_valid), 0);
        chk("rst_id", 64'(bus.irq_id), 0);
        chk("rst_data", 64'(bus.irq_data), 0);
        chk("rst_ovf", 64'(irq_ovf), 0);
        step();

        // single key
        push(1'(IRQ_KEY), 32'hDEADBEEF);
        pulse(IRQ_KEY, 32'hDEADBEEF);
        chk("t1_lat1", 64'(bus.irq_valid), 0);
        step();
        chk("t1_valid", 64'(bus.irq_valid), 1);
        do_ack();
        chk("t1_ack", 64'(bus.irq_valid), 0);
        do_done();
        step();
        chk("t1_idle", 64'(bus.irq_valid), 0);

        // priority
        push(1'(IRQ_ETH), 32'h0000_00E1);
        push(1'(IRQ_KEY), 32'h0000_00B1);
        src_irq  = 2'b11;
        src_data = {32'h0000_00B1, 32'h0000_00E1};
        step();
        src_irq = 2'b00;
        step();
        chk("t2_valid", 64'(bus.irq_valid), 1);
        chk("t2_id0", 64'(bus.irq_id), 0);
        do_ack();
        do_done();
        chk("t2_gap", 64'(bus.irq_valid), 0);
        step();
        chk("t2_id1", 64'(bus.irq_id), 1);
        do_ack();
        do_done();

        // overflow
        push(1'(IRQ_KEY), 32'h11);
        pulse(IRQ_KEY, 32'h11);
        step();
        pulse(IRQ_KEY, 32'h22);
        chk("t3_ovf", 64'(irq_ovf), 2'b10);
        chk("t3_data", 64'(bus.irq_data), 32'h11);
        do_ack();
        do_done();
        chk("t3_ovf_sticky", 64'(irq_ovf), 2'b10);
        mask_write(2'b01);
        chk("t3_ovf_clr", 64'(irq_ovf), 0);
        mask_write(2'b11);

        // masking
        mask_write(2'b10);
        pulse(IRQ_ETH, 32'hA5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_masked", 64'(bus.irq_valid), 0);
        end
        push(1'(IRQ_ETH), 32'hA5);
        mask_write(2'b11);
        chk("t4_unmask_lat", 64'(bus.irq_valid), 0);
        step();
        chk("t4_unmask", 64'(bus.irq_valid), 1);
        mask_write(2'b10);
        chk("t4_wd_hold", 64'(bus.irq_valid), 1);
        step();
        chk("t4_withdraw", 64'(bus.irq_valid), 0);
        push(1'(IRQ_ETH), 32'hA5);
        mask_write(2'b11);
        step();
        chk("t4_repres", 64'(bus.irq_valid), 1);
        do_ack();
        do_done();

        // ack/event collision
        push(1'(IRQ_KEY), 32'h44);
        pulse(IRQ_KEY, 32'h44);
        step();
        bus.irq_ack        = 1'b1;
        src_irq[IRQ_KEY]   = 1'b1;
        src_data[63:32]    = 32'h33;
        push(1'(IRQ_KEY), 32'h33);
        step();
        bus.irq_ack      = 1'b0;
        src_irq[IRQ_KEY] = 1'b0;
        chk("t5_ack", 64'(bus.irq_valid), 0);
        do_done();
        step();
        chk("t5_repend", 64'(bus.irq_valid), 1);
        chk("t5_no_ovf", 64'(irq_ovf), 0);
        do_ack();
        do_done();

        // reset mid-SERVICE with key pending, key held high through reset
        push(1'(IRQ_KEY), 32'h55);
        pulse(IRQ_KEY, 32'h55);
        step();
        do_ack();
        pulse(IRQ_KEY, 32'h66);
        src_irq[IRQ_KEY] = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_valid", 64'(bus.irq_valid), 0);
        chk("t6_id", 64'(bus.irq_id), 0);
        chk("t6_data", 64'(bus.irq_data), 0);
        chk("t6_ovf", 64'(irq_ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_held_high", 64'(bus.irq_valid), 0);
        src_irq[IRQ_KEY] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6_quiet", 64'(bus.irq_valid), 0);
        push(1'(IRQ_KEY), 32'h77);
        pulse(IRQ_KEY, 32'h77);
        step();
        chk("t6_fresh", 64'(bus.irq_valid), 1);
        do_ack();
        do_done();
        step();

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
